int_ctrl_mux: RTL
=================

# int_ctrl_mux

Parametrised multi-output interrupt controller in the clk_32k domain. It collects NW rising-edge interrupt sources into sticky status bits and tracks per-source overflow. It routes enabled pending sources to NO independent interrupt pins, each with its own polarity, level/pulse mode, pulse width and cold time. It also reports the lowest-index pending enabled source for the register block.

## Interface
- NW, 16, number of interrupt sources (2..32)
- NO, 2, number of interrupt output pins (1..4)
- IW, $clog2(NW), width of pending-id output
- clk_32k  in  1  32 kHz clock
- rst_n  in  1  asynchronous, active-low reset
- int_src  in  NW  source flags, clk_32k domain; request = rising edge
- rg_int_enable  in  NW  per-source enable (affects routing only, not status capture)
- rg_int_clr  in  NW  write-one-clear pulse for status and overflow bits
- rg_int_route  in  NW*NO  bit [o*NW+i] = route source i to output o
- rg_out_low_en  in  NO  per-output polarity: 0 active-high, 1 active-low
- rg_out_level_en  in  NO  per-output mode: 0 pulse, 1 level
- rg_int_width  in  NO*11  per-output pulse width minus 1 (1..2048 cycles)
- rg_cold_time  in  NO*6  per-output cold time code; cold = (code+1)*32 cycles
- int_status  out  NW  sticky status
- int_ovf  out  NW  sticky overflow: request while status already set
- int_pend_vld  out  1  any (status & enable) bit set
- int_pend_id  out  IW  lowest index of (status & enable); 0 when none
- int_out  out  NO  interrupt pins

## Operation
- Edge detect: `int_src_d1` register; `req = int_src & ~int_src_d1`.
- Status per bit: `req` sets, else `rg_int_clr` clears. Set wins on a same-cycle set and clear.
- Overflow per bit: set on `req & int_status`, cleared by `rg_int_clr`. A same-cycle overflow set and clear leaves it set.
- Per output o: `pend[o] = |(int_status & rg_int_enable & route[o])`.
- Per output, registered `act[o]`: `int_out[o] = act[o] ^ rg_out_low_en[o]`.
- Level mode: `act[o] <= pend[o]`; FSM held in IDLE, counter held at 0.
- Pulse mode FSM per output, with an 11-bit counter:
  - IDLE: `pend` -> ASSERT, act=1, cnt=0.
  - ASSERT: cnt increments each cycle. At cnt == width, go to COLD with act=0 and cnt=0. If `pend` drops first, go to COLD early, cnt=0.
  - COLD: act=0, cnt increments. At cnt == cold-1, go to IDLE. If `pend` is still set, IDLE re-fires on the next cycle.
- Changing `rg_out_level_en[o]` forces that output FSM to IDLE, cnt=0, act=0 in the next cycle.
- A `rg_out_low_en` change takes effect combinationally, with no FSM effect.
- Width and cold values are sampled continuously. Reducing them below the current cnt ends the state when cnt wraps past the compare value; the counter wraps modulo 2048.
- Cold counter width: 11 bits; maximum cold is 2048.
- Outputs are fully independent; one source may be routed to several outputs.

## Timing
- Reset values:
  - int_status=0, int_ovf=0, int_pend_vld=0, int_pend_id=0.
  - act=0 for all outputs, so int_out[o] = rg_out_low_en[o].
  - All FSMs in IDLE, all counters 0, int_src_d1=0.
  - A source already high at reset release produces a request on the first clock.
- Source high first sampled at edge t: int_status set after edge t, visible in cycle t+1.
- pend_vld and pend_id are combinational from status, so they are also visible in cycle t+1.
- act, and therefore int_out, changes after edge t+1 (2-cycle latency), in both modes.
- Pulse: active for width+1 cycles exactly, then inactive for at least cold cycles before the next assertion.
- Clear in cycle c, level mode: the pin deasserts after edge c+1.
- Clear in cycle c, pulse mode during ASSERT: the pin deasserts after edge c+1 and cold starts.
- Reset asserted mid-pulse returns all state to reset values asynchronously.

## Test plan
- Reset, then a pulse on src[3] with enable=all, route o0=all, level_en=0, width=3, cold=0: status[3]=1 at cycle 1; int_out[0] high for 4 cycles starting cycle 2; then low ≥32 cycles; re-pulse while status remains set.
- Level mode, low_en=1: src[5] edge -> int_out=0 two cycles later; clr[5] -> int_out=1 two cycles after the clr.
- Simultaneous `req` and `clr` on bit 2 -> status stays 1. A second edge on bit 2 while set -> int_ovf[2]=1, and clr clears both.
- Routing: src[1] routed only to o1, src[9] only to o0; assert both. Each pin pulses independently with its own width (e.g. 0 and 10). pend_id=1, and after clr[1] pend_id=9.
- Disabled source: enable[4]=0, src[4] edge -> status[4]=1, pend_vld=0, no output activity.
- Mode switch mid-ASSERT: level_en 0->1 -> FSM IDLE next cycle, then act follows pend. Async reset mid-COLD -> all outputs inactive immediately.

Source files
------------

// File: rtl/int_ctrl_mux_if.sv
// Register-side bundle of int_ctrl_mux: source flags, configuration, status and pins.
interface int_ctrl_mux_if #(
  parameter int unsigned NW = 16,
  parameter int unsigned NO = 2,
  parameter int unsigned IW = $clog2(NW)
);
  logic [NW-1:0]    int_src;
  logic [NW-1:0]    rg_int_enable;
  logic [NW-1:0]    rg_int_clr;
  logic [NW*NO-1:0] rg_int_route;
  logic [NO-1:0]    rg_out_low_en;
  logic [NO-1:0]    rg_out_level_en;
  logic [NO*11-1:0] rg_int_width;
  logic [NO*6-1:0]  rg_cold_time;
  logic [NW-1:0]    int_status;
  logic [NW-1:0]    int_ovf;
  logic             int_pend_vld;
  logic [IW-1:0]    int_pend_id;
  logic [NO-1:0]    int_out;

  // Register block / source side.
  modport master (
    output int_src, rg_int_enable, rg_int_clr, rg_int_route,
           rg_out_low_en, rg_out_level_en, rg_int_width, rg_cold_time,
    input  int_status, int_ovf, int_pend_vld, int_pend_id, int_out
  );

  // Controller side.
  modport slave (
    input  int_src, rg_int_enable, rg_int_clr, rg_int_route,
           rg_out_low_en, rg_out_level_en, rg_int_width, rg_cold_time,
    output int_status, int_ovf, int_pend_vld, int_pend_id, int_out
  );
endinterface

// File: rtl/int_ctrl_mux.sv
// Multi-output interrupt controller: edge capture into sticky status/overflow,
// per-output routing with level or pulse/cold-time generation.
module int_ctrl_mux #(
  parameter int unsigned NW = 16,
  parameter int unsigned NO = 2,
  parameter int unsigned IW = $clog2(NW)
) (
  input  logic          clk_32k,
  input  logic          rst_n,
  int_ctrl_mux_if.slave bus
);

  localparam int unsigned CW = 11;  // pulse / cold counter width
  localparam int unsigned TW = 6;   // cold time code width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_COLD   = 2'd2
  } state_e;

  logic [NW-1:0] src_d1_q;
  logic [NW-1:0] status_q, status_d;
  logic [NW-1:0] ovf_q, ovf_d;
  logic [NW-1:0] req_c;
  logic [NW-1:0] en_stat_c;
  logic [IW-1:0] pend_id_c;

  logic [NO-1:0] level_q;
  logic [NO-1:0] mode_chg_c;
  logic [NO-1:0] pend_c;
  logic [NO-1:0] act_q, act_d;
  state_e        state_q [NO];
  state_e        state_d [NO];
  logic [CW-1:0] cnt_q   [NO];
  logic [CW-1:0] cnt_d   [NO];
  logic [CW-1:0] width_c [NO];
  logic [CW-1:0] cold_m1_c [NO];

  assign req_c      = bus.int_src & ~src_d1_q;
  assign en_stat_c  = status_q & bus.rg_int_enable;
  assign mode_chg_c = bus.rg_out_level_en ^ level_q;

  // Set wins over clear for status; overflow set also wins over clear.
  always_comb begin
    status_d = req_c | (status_q & ~bus.rg_int_clr);
    ovf_d    = (req_c & status_q) | (ovf_q & ~bus.rg_int_clr);
  end

  // Lowest-index pending enabled source.
  always_comb begin
    pend_id_c = '0;
    for (int i = int'(NW) - 1; i >= 0; i--) begin
      if (en_stat_c[i]) pend_id_c = IW'(i);
    end
  end

  // Per-output pending, pulse width and last cold count (cold = (code+1)*32).
  for (genvar g = 0; g < int'(NO); g++) begin : g_out
    assign pend_c[g]    = |(en_stat_c & bus.rg_int_route[g*NW +: NW]);
    assign width_c[g]   = bus.rg_int_width[g*CW +: CW];
    assign cold_m1_c[g] = {bus.rg_cold_time[g*TW +: TW], 5'h1f};
  end

  // Source edge detect, sticky status and overflow.
  always_ff @(posedge clk_32k or negedge rst_n) begin
    if (!rst_n) begin
      src_d1_q <= '0;
      status_q <= '0;
      ovf_q    <= '0;
    end else begin
      src_d1_q <= bus.int_src;
      status_q <= status_d;
      ovf_q    <= ovf_d;
    end
  end

  // Output FSM state, counters and active flags.
  always_ff @(posedge clk_32k or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      act_q   <= '0;
      for (int o = 0; o < int'(NO); o++) begin
        state_q[o] <= ST_IDLE;
        cnt_q[o]   <= '0;
      end
    end else begin
      level_q <= bus.rg_out_level_en;
      act_q   <= act_d;
      for (int o = 0; o < int'(NO); o++) begin
        state_q[o] <= state_d[o];
        cnt_q[o]   <= cnt_d[o];
      end
    end
  end

  // Output FSM next state: mode change resets, level follows pend, pulse runs ASSERT/COLD.
  always_comb begin
    act_d   = act_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int o = 0; o < int'(NO); o++) begin
      if (mode_chg_c[o]) begin
        state_d[o] = ST_IDLE;
        cnt_d[o]   = '0;
        act_d[o]   = 1'b0;
      end else if (bus.rg_out_level_en[o]) begin
        state_d[o] = ST_IDLE;
        cnt_d[o]   = '0;
        act_d[o]   = pend_c[o];
      end else begin
        case (state_q[o])
          ST_IDLE: begin
            act_d[o] = 1'b0;
            cnt_d[o] = '0;
            if (pend_c[o]) begin
              state_d[o] = ST_ASSERT;
              act_d[o]   = 1'b1;
            end
          end
          ST_ASSERT: begin
            if (!pend_c[o] || (cnt_q[o] == width_c[o])) begin
              state_d[o] = ST_COLD;
              act_d[o]   = 1'b0;
              cnt_d[o]   = '0;
            end else begin
              cnt_d[o] = cnt_q[o] + CW'(1);
            end
          end
          ST_COLD: begin
            act_d[o] = 1'b0;
            if (cnt_q[o] == cold_m1_c[o]) begin
              state_d[o] = ST_IDLE;
              cnt_d[o]   = '0;
            end else begin
              cnt_d[o] = cnt_q[o] + CW'(1);
            end
          end
          default: begin
            state_d[o] = ST_IDLE;
            cnt_d[o]   = '0;
            act_d[o]   = 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.int_status   = status_q;
  assign bus.int_ovf      = ovf_q;
  assign bus.int_pend_vld = |en_stat_c;
  assign bus.int_pend_id  = pend_id_c;
  assign bus.int_out      = act_q ^ bus.rg_out_low_en;

endmodule
